// File: rtl/md_ctrl_pkg.sv
// md_ctrl_pkg: shared definitions for the multiply/divide controller.
//   - md_op encodings for the HI/LO operations issued from EX
//   - IDLE/RUN state encoding of the sequencing FSM
//   - small decode helpers used by md_ctrl and md_calc
package md_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Multi-cycle ops are the four arithmetic codes 0..3.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == 3'd2) || (op == 3'd3);
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational 64-bit result generator for the HI/LO unit.
//   op       in  3   md_op code (only MULT/MULTU/DIV/DIVU are meaningful)
//   a        in  32  rs operand (multiplicand / dividend)
//   b        in  32  rt operand (multiplier / divisor)
//   result   out 64  {HI,LO}: product, or {remainder, quotient} for divides
//   div_zero out 1   divide op with b==0; result is then don't-care
// Signed ops are done on magnitudes and the signs reapplied, which also
// gives the wrapped 0x80000000 / -1 = 0x80000000, remainder 0 case for free.
module md_calc
  import md_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [63:0] prod_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_val;
  logic [31:0] r_val;

  always_comb begin
    sgn      = (op == MD_MULT) || (op == MD_DIV);
    a_neg    = sgn & a[31];
    b_neg    = sgn & b[31];
    a_mag    = a_neg ? (32'd0 - a) : a;
    b_mag    = b_neg ? (32'd0 - b) : b;
    div_zero = is_div_op(op) && (b == 32'd0);
    // Substitute 1 for a zero divisor so the divider never sees 0.
    divisor  = (b == 32'd0) ? 32'd1 : b_mag;
    prod_mag = {32'd0, a_mag} * {32'd0, b_mag};
    q_mag    = a_mag / divisor;
    r_mag    = a_mag % divisor;
    q_val    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    // Remainder follows the sign of the dividend.
    r_val    = a_neg ? (32'd0 - r_mag) : r_mag;
    if (is_div_op(op)) begin
      result = {r_val, q_val};
    end else begin
      result = (a_neg ^ b_neg) ? (64'd0 - prod_mag) : prod_mag;
    end
  end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: sequencing controller and HI/LO owner for the EX-stage
// multiply/divide unit.
//   clk    in  1   rising-edge clock
//   reset  in  1   asynchronous active-low reset
//   start  in  1   issue strobe, one cycle per instruction
//   md_op  in  3   MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   A, B   in  32  forwarded rs / rt operands
//   cancel in  1   (only with MD_CANCEL_EN) flush of in-flight/issuing op
//   busy   out 1   high for exactly MUL_CYCLES / DIV_CYCLES cycles per op
//   done   out 1   one-cycle pulse in the first cycle new HI/LO are visible
//   HI, LO out 32  architectural HI/LO registers
// Optional feature macro: MD_CANCEL_EN adds the cancel input.
// The result is computed at acceptance into a shadow register; the counter
// only models latency, so HI/LO change only at the RUN->IDLE edge.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [63:0]      shadow_reg, shadow_next;
  logic             zero_reg, zero_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic [63:0]      calc_result;
  logic             calc_zero;
  logic             cancel_w;

`ifdef MD_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  md_calc u_calc (
    .op       (md_op),
    .a        (A),
    .b        (B),
    .result   (calc_result),
    .div_zero (calc_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      shadow_reg <= '0;
      zero_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      shadow_reg <= shadow_next;
      zero_reg   <= zero_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    shadow_next = shadow_reg;
    zero_next   = zero_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    done_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start && !cancel_w) begin
          if (is_long_op(md_op)) begin
            state_next  = ST_RUN;
            shadow_next = calc_result;
            zero_next   = calc_zero;
            count_next  = is_div_op(md_op) ? DIV_LOAD : MUL_LOAD;
          end else if (md_op == MD_MTHI) begin
            hi_next = A;
          end else if (md_op == MD_MTLO) begin
            lo_next = A;
          end
        end
      end
      ST_RUN: begin
        // start is deliberately not looked at here: issue while busy is ignored.
        if (cancel_w) begin
          state_next = ST_IDLE;
          count_next = '0;
        end else if (count_reg == '0) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
          // A zero divisor still takes full latency but leaves HI/LO alone.
          if (!zero_reg) begin
            hi_next = shadow_reg[63:32];
            lo_next = shadow_reg[31:0];
          end
        end else begin
          count_next = count_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase

    busy_next = (state_next == ST_RUN);
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: scoreboard bench for md_ctrl. Issued mult/div ops push the
// expected {HI,LO} into a queue; a monitor pops and compares on each done.
module tb_md_ctrl;
  import md_ctrl_pkg::*;

  localparam int MUL_C = 5;
  localparam int DIV_C = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
`ifdef MD_CANCEL_EN
  logic        cancel = 1'b0;
`endif
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  always #5 clk = ~clk;

  md_ctrl #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
`ifdef MD_CANCEL_EN
    .cancel(cancel),
`endif
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the operands.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {hi, lo};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return {hi, lo};
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset && done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected done=0");
        end else begin
          e = exp_q.pop_front();
          check("done_hi", HI, e[63:32]);
          check("done_lo", LO, e[31:0]);
        end
      end
    end
  end

  // Issue one op; must be called at a negedge. Returns at a negedge with the
  // DUT idle, so a following call issues in the done cycle (back-to-back).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    logic [63:0] e;
    int n;
    int lat;
    start = 1'b1;
    md_op = op;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    if (op <= 3'd3) begin
      e = ref_model(op, a, b, hi_m, lo_m);
      exp_q.push_back(e);
      hi_m = e[63:32];
      lo_m = e[31:0];
      lat  = (op >= 3'd2) ? DIV_C : MUL_C;
      n    = 0;
      while (busy && n < 100) begin
        n++;
        if (inject && n == 2) begin
          start = 1'b1;
          md_op = MD_MULT;
          A     = 32'h0000_1234;
          B     = 32'h0000_5678;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
      start = 1'b0;
      check($sformatf("busy_cycles op%0d", op), 32'(n), 32'(lat));
    end else begin
      if (op == 3'd4) hi_m = a;
      if (op == 3'd5) lo_m = a;
      check($sformatf("busy_single op%0d", op), {31'd0, busy}, 32'd0);
      check($sformatf("hi_after op%0d", op), HI, hi_m);
      check($sformatf("lo_after op%0d", op), LO, lo_m);
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_hi_const", HI, 32'hFFFF_FFFF);
    check("mult_lo_const", LO, 32'hFFFF_FFFA);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_hi_const", HI, 32'hFFFF_FFFE);
    check("multu_lo_const", LO, 32'h0000_0001);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_hi_const", HI, 32'hFFFF_FFFF);
    check("div_lo_const", LO, 32'hFFFF_FFFD);
    run_op(MD_DIVU, 32'd7, 32'd0, 1'b0);
    check("divu0_hi_const", HI, 32'hFFFF_FFFF);
    check("divu0_lo_const", LO, 32'hFFFF_FFFD);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_hi_const", HI, 32'h0000_0000);
    check("div_ovf_lo_const", LO, 32'h8000_0000);
    run_op(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    run_op(MD_MULT, 32'd9, 32'hFFFF_FFFF, 1'b1);
    run_op(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
    run_op(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0);

    // Async reset in the middle of a DIV.
    run_op(MD_MTHI, 32'hAAAA_5555, 32'd0, 1'b0);
    run_op(MD_MTLO, 32'h5555_AAAA, 32'd0, 1'b0);
    start = 1'b1;
    md_op = MD_DIV;
    A     = 32'd100;
    B     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_hi", HI, 32'd0);
    check("async_lo", LO, 32'd0);
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
    reset = 1'b1;
    run_op(MD_MTLO, 32'd5, 32'd0, 1'b0);

`ifdef MD_CANCEL_EN
    run_op(MD_MTHI, 32'd1, 32'd0, 1'b0);
    run_op(MD_MTLO, 32'd2, 32'd0, 1'b0);
    start = 1'b1;
    md_op = MD_MULT;
    A     = 32'd6;
    B     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", {31'd0, busy}, 32'd0);
    check("cancel_hi", HI, 32'd1);
    check("cancel_lo", LO, 32'd2);
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    run_op(MD_MTHI, 32'h0BAD_0BAD, 32'd0, 1'b0);
    cancel = 1'b0;
    hi_m = 32'd1;
    check("cancel_mthi", HI, 32'd1);
`endif

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = {24'd0, rb[7:0]};
        default: ;
      endcase
      run_op(rop, ra, rb, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
